cfg_column_arbiter: RTL and testbench
=====================================

# cfg_column_arbiter

Parametrised configuration-bus front end for the CGRA array. It accepts independent configuration requests from `NUM_CH` column-side masters and serialises them onto the single shared config bus of the interconnect. Arbitration is round-robin with per-channel stall masking. Read transactions wait a fixed interconnect latency; the returned `read_config_data` is routed back tagged with the issuing channel. It sits between the global controller's per-column config ports and the interconnect's config/read-data ports.

## Interface
- `NUM_CH`, 12, number of requesting channels (≥2)
- `ADDR_W`, 32, config address width
- `DATA_W`, 32, config data width
- `RD_LAT`, 2, cycles from `config_read` pulse to valid `read_config_data` (≥1)
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `stall`  in  NUM_CH  per-channel stall; a stalled channel is not granted
- `req_valid`  in  NUM_CH  channel i has a pending request
- `req_ready`  out  NUM_CH  one-hot grant; the request is accepted when valid&ready
- `req_addr`  in  NUM_CH*ADDR_W  flattened; channel i at [i*ADDR_W +: ADDR_W]
- `req_data`  in  NUM_CH*DATA_W  flattened write data
- `req_read`  in  NUM_CH  1 = read, 0 = write
- `config_addr`  out  ADDR_W  shared bus address
- `config_data`  out  DATA_W  shared bus write data
- `config_read`  out  1  one-cycle read strobe
- `config_write`  out  1  one-cycle write strobe
- `read_config_data`  in  DATA_W  interconnect read return
- `rd_valid`  out  1  one-cycle read-response strobe
- `rd_data`  out  DATA_W  captured read data
- `rd_ch`  out  $clog2(NUM_CH)  channel that issued the read
- `wr_count`  out  16  writes issued (statistics)
- `rd_count`  out  16  reads issued (statistics)

## Operation
- FSM states:
  - IDLE: grants are allowed.
  - RD_WAIT: a read is outstanding; no grants.
- Eligible channel: `req_valid[i] & ~stall[i]`.
- Arbitration:
  - Round-robin pointer `ptr` gives highest priority to channel `ptr`, then `ptr+1`, and so on, wrapping modulo NUM_CH.
  - In IDLE with at least one eligible channel, `req_ready` is asserted combinationally, one-hot, for the winner.
  - On acceptance, `ptr` ← winner+1 (wraps to 0 after NUM_CH-1).
- Accepted write: on the next cycle, `config_write`=1 and `config_addr`/`config_data` hold the request. The FSM stays in IDLE, giving back-to-back writes at one per cycle.
- Accepted read:
  - On the next cycle, `config_read`=1 and `config_addr` is driven. `config_data` holds its previous value.
  - The FSM enters RD_WAIT, loads a latency counter, and stores the channel id.
- RD_WAIT:
  - On the RD_LAT-th cycle after the `config_read` cycle, `read_config_data` is sampled.
  - On the following cycle: `rd_valid`=1, `rd_data`=sample, `rd_ch`=stored id, and the FSM returns to IDLE.
  - A new grant is allowed in that same cycle.
- Outside their strobes, `rd_data`/`rd_ch` hold their last values.
- `stall` only gates new grants. An outstanding read always completes.
- Asserting `stall` in the same cycle as `req_valid` means no grant to that channel.
- Reset (any cycle, including mid-read):
  - FSM → IDLE, `ptr`=0.
  - All outputs 0.
  - An outstanding read is dropped: no `rd_valid` is produced.
  - Counters cleared.

## Timing
- Write: accept at T, bus strobe at T+1.
- Read: accept at T, `config_read` at T+1, `read_config_data` sampled at T+1+RD_LAT, `rd_valid` at T+2+RD_LAT.
- Read occupancy: RD_LAT+2 cycles from accept to the next possible grant (cycle T+2+RD_LAT).
- `req_ready` is combinational from `req_valid`, `stall`, `ptr`, and state. All other outputs are registered.

## Configuration
- `CFG_ARB_STATS_EN` defined:
  - `wr_count`/`rd_count` increment on each `config_write`/`config_read` strobe.
  - The counters saturate at 16'hFFFF and clear on reset.
- Not defined: `wr_count` and `rd_count` are tied to 0 and no counter logic is built.

## Test plan
- Round-robin fairness: ch0, ch3, and ch11 all hold `req_valid` with writes and the pointer is at 0 after reset. Required grant order: 0, 3, 11, 0.
  - Strobes are on consecutive cycles.
  - `config_addr` matches each channel's `req_addr`.
- Stall: ch2 and ch5 request with `stall[2]`=1. Required: only ch5 is granted. Then deassert `stall[2]` → ch2 is granted next cycle.
- Read, RD_LAT=2: ch7 reads addr 0x0000_0104 and the stub returns 0xDEAD_BEEF at the sample cycle.
  - Required: `rd_valid` 4 cycles after accept, with `rd_data`=0xDEAD_BEEF and `rd_ch`=7.
  - No grants during RD_WAIT.
- Read followed by a queued write: ch1 issues a read, ch4 has a pending write. Required: ch4 is granted in the `rd_valid` cycle and its `config_write` strobes on the next cycle.
- Reset mid-read: assert `reset` one cycle after `config_read`. Required:
  - No `rd_valid`.
  - All outputs 0.
  - After release, ch0 has priority.
- With `CFG_ARB_STATS_EN`: 3 writes and 2 reads → `wr_count`=3, `rd_count`=2. Force 65536 writes → `wr_count` stays at 16'hFFFF.

Source files
------------

// File: rtl/cfg_column_arbiter.sv
// Round-robin front end that serialises per-column configuration requests onto the shared config bus.
// Optional write/read statistics counters are built only when CFG_ARB_STATS_EN is defined.
module cfg_column_arbiter #(
    parameter int NUM_CH = 12,
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic [NUM_CH-1:0]          stall,
    input  logic [NUM_CH-1:0]          req_valid,
    output logic [NUM_CH-1:0]          req_ready,
    input  logic [NUM_CH*ADDR_W-1:0]   req_addr,
    input  logic [NUM_CH*DATA_W-1:0]   req_data,
    input  logic [NUM_CH-1:0]          req_read,
    output logic [ADDR_W-1:0]          config_addr,
    output logic [DATA_W-1:0]          config_data,
    output logic                       config_read,
    output logic                       config_write,
    input  logic [DATA_W-1:0]          read_config_data,
    output logic                       rd_valid,
    output logic [DATA_W-1:0]          rd_data,
    output logic [$clog2(NUM_CH)-1:0]  rd_ch,
    output logic [15:0]                wr_count,
    output logic [15:0]                rd_count
);

    localparam int CH_W  = $clog2(NUM_CH);
    localparam int CNT_W = $clog2(RD_LAT + 1);

    typedef enum logic {
        IDLE,
        RD_WAIT
    } state_t;

    state_t              state_q, state_d;
    logic [CH_W-1:0]     ptr_q, ptr_d;
    logic [CNT_W-1:0]    lat_cnt_q, lat_cnt_d;
    logic [CH_W-1:0]     pend_ch_q, pend_ch_d;
    logic [ADDR_W-1:0]   config_addr_q, config_addr_d;
    logic [DATA_W-1:0]   config_data_q, config_data_d;
    logic                config_read_q, config_read_d;
    logic                config_write_q, config_write_d;
    logic                rd_valid_q, rd_valid_d;
    logic [DATA_W-1:0]   rd_data_q, rd_data_d;
    logic [CH_W-1:0]     rd_ch_q, rd_ch_d;

    logic [NUM_CH-1:0]   eligible;
    logic [CH_W-1:0]     scan_idx;
    logic [CH_W-1:0]     win_idx;
    logic                win_found;
    logic                accept;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_data;
    logic                win_read;

    assign eligible = req_valid & ~stall;

    // Scan from the pointer upward (wrapping); the first eligible channel wins.
    always_comb begin
        scan_idx  = '0;
        win_idx   = '0;
        win_found = 1'b0;
        for (int k = 0; k < NUM_CH; k++) begin
            scan_idx = CH_W'((int'(ptr_q) + k) % NUM_CH);
            if (!win_found && eligible[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    assign accept   = win_found && (state_q == IDLE);
    assign win_addr = req_addr[win_idx*ADDR_W +: ADDR_W];
    assign win_data = req_data[win_idx*DATA_W +: DATA_W];
    assign win_read = req_read[win_idx];

    always_comb begin
        req_ready = '0;
        if (accept) begin
            req_ready[win_idx] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q        <= IDLE;
            ptr_q          <= '0;
            lat_cnt_q      <= '0;
            pend_ch_q      <= '0;
            config_addr_q  <= '0;
            config_data_q  <= '0;
            config_read_q  <= 1'b0;
            config_write_q <= 1'b0;
            rd_valid_q     <= 1'b0;
            rd_data_q      <= '0;
            rd_ch_q        <= '0;
        end else begin
            state_q        <= state_d;
            ptr_q          <= ptr_d;
            lat_cnt_q      <= lat_cnt_d;
            pend_ch_q      <= pend_ch_d;
            config_addr_q  <= config_addr_d;
            config_data_q  <= config_data_d;
            config_read_q  <= config_read_d;
            config_write_q <= config_write_d;
            rd_valid_q     <= rd_valid_d;
            rd_data_q      <= rd_data_d;
            rd_ch_q        <= rd_ch_d;
        end
    end

    // A read leaves config_data untouched so the bus only changes the fields it actually uses.
    always_comb begin
        state_d        = state_q;
        ptr_d          = ptr_q;
        lat_cnt_d      = lat_cnt_q;
        pend_ch_d      = pend_ch_q;
        config_addr_d  = config_addr_q;
        config_data_d  = config_data_q;
        config_read_d  = 1'b0;
        config_write_d = 1'b0;
        rd_valid_d     = 1'b0;
        rd_data_d      = rd_data_q;
        rd_ch_d        = rd_ch_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    ptr_d         = (win_idx == CH_W'(NUM_CH - 1)) ? '0 : win_idx + 1'b1;
                    config_addr_d = win_addr;
                    if (win_read) begin
                        config_read_d = 1'b1;
                        lat_cnt_d     = CNT_W'(RD_LAT);
                        pend_ch_d     = win_idx;
                        state_d       = RD_WAIT;
                    end else begin
                        config_write_d = 1'b1;
                        config_data_d  = win_data;
                    end
                end
            end
            RD_WAIT: begin
                if (lat_cnt_q == '0) begin
                    rd_valid_d = 1'b1;
                    rd_data_d  = read_config_data;
                    rd_ch_d    = pend_ch_q;
                    state_d    = IDLE;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign config_addr  = config_addr_q;
    assign config_data  = config_data_q;
    assign config_read  = config_read_q;
    assign config_write = config_write_q;
    assign rd_valid     = rd_valid_q;
    assign rd_data      = rd_data_q;
    assign rd_ch        = rd_ch_q;

`ifdef CFG_ARB_STATS_EN
    logic [15:0] wr_count_q;
    logic [15:0] rd_count_q;

    // Counters advance on the same edge that raises the bus strobe and stick at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_count_q <= '0;
            rd_count_q <= '0;
        end else begin
            if (config_write_d && (wr_count_q != 16'hFFFF)) begin
                wr_count_q <= wr_count_q + 16'd1;
            end
            if (config_read_d && (rd_count_q != 16'hFFFF)) begin
                rd_count_q <= rd_count_q + 16'd1;
            end
        end
    end

    assign wr_count = wr_count_q;
    assign rd_count = rd_count_q;
`else
    assign wr_count = '0;
    assign rd_count = '0;
`endif

endmodule

// File: tb/tb_cfg_column_arbiter.sv
// Scoreboard bench for cfg_column_arbiter: stimulus queues expected bus/response items, a monitor checks them.
module tb_cfg_column_arbiter;

    localparam int NUM_CH = 12;
    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;
    localparam int CH_W   = $clog2(NUM_CH);

    logic                      clk = 1'b0;
    logic                      reset;
    logic [NUM_CH-1:0]         stall;
    logic [NUM_CH-1:0]         req_valid;
    logic [NUM_CH-1:0]         req_ready;
    logic [NUM_CH*ADDR_W-1:0]  req_addr;
    logic [NUM_CH*DATA_W-1:0]  req_data;
    logic [NUM_CH-1:0]         req_read;
    logic [ADDR_W-1:0]         config_addr;
    logic [DATA_W-1:0]         config_data;
    logic                      config_read;
    logic                      config_write;
    logic [DATA_W-1:0]         read_config_data;
    logic                      rd_valid;
    logic [DATA_W-1:0]         rd_data;
    logic [CH_W-1:0]           rd_ch;
    logic [15:0]               wr_count;
    logic [15:0]               rd_count;

    logic [ADDR_W-1:0] addrArr [NUM_CH];
    logic [DATA_W-1:0] dataArr [NUM_CH];

    typedef struct {
        logic              isRead;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        int                cycle;
    } busItem_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                ch;
        int                cycle;
    } rspItem_t;

    busItem_t busQ [$];
    rspItem_t rspQ [$];

    int                cyc = 0;
    int                total = 0;
    int                bad = 0;
    int                rdSampleCyc = -1;
    logic [DATA_W-1:0] stubVal = '0;
    logic [DATA_W-1:0] lastWrData = '0;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_pack
        assign req_addr[g*ADDR_W +: ADDR_W] = addrArr[g];
        assign req_data[g*DATA_W +: DATA_W] = dataArr[g];
    end

    cfg_column_arbiter #(
        .NUM_CH(NUM_CH),
        .ADDR_W(ADDR_W),
        .DATA_W(DATA_W),
        .RD_LAT(RD_LAT)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .stall            (stall),
        .req_valid        (req_valid),
        .req_ready        (req_ready),
        .req_addr         (req_addr),
        .req_data         (req_data),
        .req_read         (req_read),
        .config_addr      (config_addr),
        .config_data      (config_data),
        .config_read      (config_read),
        .config_write     (config_write),
        .read_config_data (read_config_data),
        .rd_valid         (rd_valid),
        .rd_data          (rd_data),
        .rd_ch            (rd_ch),
        .wr_count         (wr_count),
        .rd_count         (rd_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Interconnect stub: returns stubVal only in the cycle the arbiter should sample it.
    always @(negedge clk) begin
        if (config_read) rdSampleCyc = cyc + RD_LAT;
        read_config_data = (cyc == rdSampleCyc) ? stubVal : (32'hBAD0_0000 ^ 32'(cyc));
    end

    // Monitor: every bus strobe and read response must match the oldest queued expectation.
    always @(negedge clk) begin
        busItem_t b;
        rspItem_t r;
        if (config_write || config_read) begin
            if (busQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL busUnexpected: actual strobe addr=%0h required no strobe (cycle %0d)", config_addr, cyc);
            end else begin
                b = busQ.pop_front();
                checkOutput("busCycle", 64'(cyc), 64'(b.cycle));
                checkOutput("busIsRead", 64'(config_read), 64'(b.isRead));
                checkOutput("busWriteStrobe", 64'(config_write), 64'(!b.isRead));
                checkOutput("busAddr", 64'(config_addr), 64'(b.addr));
                checkOutput("busData", 64'(config_data), 64'(b.data));
            end
        end
        if (rd_valid) begin
            if (rspQ.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL rspUnexpected: actual rd_valid ch=%0d required none (cycle %0d)", rd_ch, cyc);
            end else begin
                r = rspQ.pop_front();
                checkOutput("rspCycle", 64'(cyc), 64'(r.cycle));
                checkOutput("rspData", 64'(rd_data), 64'(r.data));
                checkOutput("rspCh", 64'(rd_ch), 64'(r.ch));
            end
        end
    end

    task automatic applyStimulus(input int ch, input logic rd, input logic [ADDR_W-1:0] a,
                                 input logic [DATA_W-1:0] d);
        req_valid[ch] = 1'b1;
        req_read[ch]  = rd;
        addrArr[ch]   = a;
        dataArr[ch]   = d;
    endtask

    task automatic dropReq(input int ch);
        req_valid[ch] = 1'b0;
    endtask

    // Checks the grant vector and queues what the grant must produce on the bus (ch < 0: no grant).
    task automatic expectGrant(input string name, input int ch, input bit expectRsp);
        logic [NUM_CH-1:0] oneHot;
        busItem_t b;
        rspItem_t r;
        #1;
        oneHot = '0;
        if (ch >= 0) oneHot[ch] = 1'b1;
        checkOutput(name, 64'(req_ready), 64'(oneHot));
        if (ch >= 0) begin
            b.isRead = req_read[ch];
            b.addr   = addrArr[ch];
            b.cycle  = cyc + 1;
            if (req_read[ch]) begin
                b.data = lastWrData;
                if (expectRsp) begin
                    r.data  = stubVal;
                    r.ch    = ch;
                    r.cycle = cyc + 2 + RD_LAT;
                    rspQ.push_back(r);
                end
            end else begin
                b.data     = dataArr[ch];
                lastWrData = dataArr[ch];
            end
            busQ.push_back(b);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_addr"}, 64'(config_addr), 64'd0);
        checkOutput({tag, "_data"}, 64'(config_data), 64'd0);
        checkOutput({tag, "_read"}, 64'(config_read), 64'd0);
        checkOutput({tag, "_write"}, 64'(config_write), 64'd0);
        checkOutput({tag, "_rdValid"}, 64'(rd_valid), 64'd0);
        checkOutput({tag, "_rdData"}, 64'(rd_data), 64'd0);
        checkOutput({tag, "_rdCh"}, 64'(rd_ch), 64'd0);
        checkOutput({tag, "_wrCount"}, 64'(wr_count), 64'd0);
        checkOutput({tag, "_rdCount"}, 64'(rd_count), 64'd0);
    endtask

    task automatic doRead(input int ch, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] v);
        @(negedge clk);
        stubVal = v;
        applyStimulus(ch, 1'b1, a, '0);
        expectGrant("statsReadGrant", ch, 1'b1);
        @(negedge clk);
        dropReq(ch);
        repeat (RD_LAT + 2) @(negedge clk);
    endtask

    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset     = 1'b1;
        stall     = '0;
        req_valid = '0;
        req_read  = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            addrArr[i] = '0;
            dataArr[i] = '0;
        end
        repeat (3) @(negedge clk);
        checkAllZero("resetState");
        reset = 1'b0;

        // Fairness: ch0, ch3, ch11 pending from ptr 0 -> 0, 3, 11, 0 on consecutive cycles.
        @(negedge clk);
        applyStimulus(0, 1'b0, 32'h0000_0A00, 32'h1111_0000);
        applyStimulus(3, 1'b0, 32'h0000_0A03, 32'h3333_0000);
        applyStimulus(11, 1'b0, 32'h0000_0A0B, 32'hBBBB_0000);
        expectGrant("rrGrant0", 0, 1'b0);
        @(negedge clk);
        applyStimulus(0, 1'b0, 32'h0000_0B00, 32'h1111_0001);
        expectGrant("rrGrant3", 3, 1'b0);
        @(negedge clk);
        dropReq(3);
        expectGrant("rrGrant11", 11, 1'b0);
        @(negedge clk);
        dropReq(11);
        expectGrant("rrGrant0again", 0, 1'b0);
        @(negedge clk);
        dropReq(0);
        expectGrant("rrIdle", -1, 1'b0);

        // Stall masking, ptr now 1.
        @(negedge clk);
        stall[2] = 1'b1;
        applyStimulus(2, 1'b0, 32'h0000_0C02, 32'h2222_0000);
        expectGrant("stallOnlyStalled", -1, 1'b0);
        @(negedge clk);
        applyStimulus(5, 1'b0, 32'h0000_0C05, 32'h5555_0000);
        expectGrant("stallGrant5", 5, 1'b0);
        @(negedge clk);
        dropReq(5);
        stall[2] = 1'b0;
        expectGrant("unstallGrant2", 2, 1'b0);
        @(negedge clk);
        dropReq(2);

        // Read from ch7 (ptr 3); ch9 waits through RD_WAIT and is granted in the rd_valid cycle.
        stubVal = 32'hDEAD_BEEF;
        applyStimulus(7, 1'b1, 32'h0000_0104, '0);
        expectGrant("readGrant7", 7, 1'b1);
        for (int i = 1; i <= RD_LAT + 1; i++) begin
            @(negedge clk);
            if (i == 1) begin
                dropReq(7);
                applyStimulus(9, 1'b0, 32'h0000_0900, 32'h9999_0000);
            end
            expectGrant("noGrantRdWait", -1, 1'b0);
        end
        @(negedge clk);
        expectGrant("grant9AtRdValid", 9, 1'b0);
        @(negedge clk);
        dropReq(9);

        // ch1 read with ch4 write queued (ptr 10): ch1 first, ch4 in the rd_valid cycle.
        stubVal = 32'hCAFE_0001;
        applyStimulus(1, 1'b1, 32'h0000_0110, '0);
        applyStimulus(4, 1'b0, 32'h0000_0404, 32'h4444_0000);
        expectGrant("readGrant1", 1, 1'b1);
        @(negedge clk);
        dropReq(1);
        expectGrant("ch4HeldDuringRead", -1, 1'b0);
        repeat (RD_LAT) begin
            @(negedge clk);
            expectGrant("ch4HeldDuringRead", -1, 1'b0);
        end
        @(negedge clk);
        checkOutput("rdValidWithCh4Grant", 64'(rd_valid), 64'd1);
        expectGrant("grant4AtRdValid", 4, 1'b0);
        @(negedge clk);
        dropReq(4);

        // Reset one cycle after config_read of a ch6 read: no response, everything cleared.
        stubVal = 32'h5555_AAAA;
        applyStimulus(6, 1'b1, 32'h0000_0200, '0);
        expectGrant("readGrant6", 6, 1'b0);
        @(negedge clk);
        dropReq(6);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        lastWrData = '0;
        checkAllZero("midReadReset");
        @(negedge clk);
        reset = 1'b0;
        repeat (4) @(negedge clk);
        checkOutput("noRspAfterReset", 64'(rspQ.size()), 64'd0);

        // ptr back at 0: ch0 beats ch6 and ch11; these three writes and two reads feed the counters.
        applyStimulus(11, 1'b0, 32'h0000_0D0B, 32'hB0B0_0000);
        applyStimulus(6, 1'b0, 32'h0000_0D06, 32'h6060_0000);
        applyStimulus(0, 1'b0, 32'h0000_0D00, 32'h0000_1234);
        expectGrant("postResetGrant0", 0, 1'b0);
        @(negedge clk);
        dropReq(0);
        expectGrant("postResetGrant6", 6, 1'b0);
        @(negedge clk);
        dropReq(6);
        expectGrant("postResetGrant11", 11, 1'b0);
        @(negedge clk);
        dropReq(11);
        doRead(5, 32'h0000_0E05, 32'h0E05_0E05);
        doRead(8, 32'h0000_0E08, 32'h0E08_0E08);
        @(negedge clk);
`ifdef CFG_ARB_STATS_EN
        checkOutput("wrCount3", 64'(wr_count), 64'd3);
        checkOutput("rdCount2", 64'(rd_count), 64'd2);
        applyStimulus(0, 1'b0, 32'h0000_0F00, 32'hF0F0_F0F0);
        repeat (65536) begin
            expectGrant("satGrant", 0, 1'b0);
            @(negedge clk);
        end
        dropReq(0);
        repeat (3) @(negedge clk);
        checkOutput("wrCountSaturated", 64'(wr_count), 64'hFFFF);
        checkOutput("rdCountUnchanged", 64'(rd_count), 64'd2);
`else
        checkOutput("wrCountTiedOff", 64'(wr_count), 64'd0);
        checkOutput("rdCountTiedOff", 64'(rd_count), 64'd0);
`endif
        repeat (3) @(negedge clk);
        checkOutput("busQueueDrained", 64'(busQ.size()), 64'd0);
        checkOutput("rspQueueDrained", 64'(rspQ.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
